// File: rtl/shared_dbram_responder_pkg.sv
// Shared definitions for the dual-core local data-memory responder.
// Contents:
//   REQ_ADDR_W       - word address width carried on the bus (byte address [31:2])
//   LOCAL_MEM_WORDS  - default memory depth in 32-bit words
//   local_mem_req_t  - one captured request (addr, byte enables, data, valid)
package shared_dbram_responder_pkg;

   localparam int REQ_ADDR_W      = 30;
   localparam int LOCAL_MEM_WORDS = 4096;

   typedef struct packed {
      logic [REQ_ADDR_W-1:0] addr;
      logic [3:0]            be;
      logic [31:0]           data;
      logic                  valid;
   } local_mem_req_t;

endpackage

// File: rtl/shared_dbram_responder_if.sv
// One data-BRAM port between a core (master) and the shared responder (slave).
// Signals:
//   en       master->slave  request strobe, one cycle per request
//   addr     master->slave  word address
//   be       master->slave  byte enables, 4'b0000 means read
//   data_in  master->slave  write data
//   data_out slave->master  read data, holds until this port's next read completes
//   rvalid   slave->master  one-cycle pulse marking a read result on data_out
//   busy     slave->master  a request of this port is held; en is ignored
interface shared_dbram_responder_if;
   import shared_dbram_responder_pkg::*;

   logic                  en;
   logic [REQ_ADDR_W-1:0] addr;
   logic [3:0]            be;
   logic [31:0]           data_in;
   logic [31:0]           data_out;
   logic                  rvalid;
   logic                  busy;

   modport master (output en, addr, be, data_in, input data_out, rvalid, busy);
   modport slave  (input en, addr, be, data_in, output data_out, rvalid, busy);
endinterface

// File: rtl/shared_dbram_responder_byte_en_bram.sv
// byte_en_bram: single-port LINES x 32 memory with per-byte write enables and
// a registered read. The read register only changes on a read access, so it
// keeps the last read word across writes and idle cycles.
// Ports:
//   clk    clock
//   en     access strobe
//   we     byte write enables; all zero selects a read
//   addr   word index
//   wdata  write data, byte lanes aligned to we
//   rdata  registered read data
module byte_en_bram #(
   parameter  int LINES  = 4096,
   localparam int ADDR_W = $clog2(LINES)
) (
   input  logic              clk,
   input  logic              en,
   input  logic [3:0]        we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem_r [LINES];

   // Array access: byte-lane writes or a registered word read.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we != 4'b0000) begin
            for (int b = 0; b < 4; b++) begin
               if (we[b]) begin
                  mem_r[addr][b*8 +: 8] <= wdata[b*8 +: 8];
               end
            end
         end else begin
            rdata <= mem_r[addr];
         end
      end
   end

endmodule

// File: rtl/shared_dbram_responder.sv
// shared_dbram_responder: serves the data-BRAM ports of both cores from one
// shared single-port memory, one access per cycle, round-robin on collisions.
// A losing fresh request is parked in its port's hold register and served on
// the following cycle while the port reports busy.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   p0, p1           per-core request/response ports (slave modport)
//   collision_count  fresh-vs-fresh collision counter, saturating; present
//                    only when SHARED_DBRAM_COLLISION_COUNT_EN is defined
module shared_dbram_responder
   import shared_dbram_responder_pkg::*;
#(
   parameter  int LINES  = LOCAL_MEM_WORDS,
   localparam int ADDR_W = $clog2(LINES)
) (
   input logic                      clk,
   input logic                      rst,
   shared_dbram_responder_if.slave  p0,
   shared_dbram_responder_if.slave  p1
`ifdef SHARED_DBRAM_COLLISION_COUNT_EN
   ,
   output logic [31:0]              collision_count
`endif
);

   local_mem_req_t fresh_req_s [2];
   local_mem_req_t hold_r      [2];
   local_mem_req_t grant_req_s;
   logic [1:0]     fresh_v_s;
   logic [1:0]     latch_s;
   logic           grant_v_s;
   logic           grant_port_s;
   logic           grant_rd_s;
   logic           collision_s;
   logic           rr_ptr_r;
   logic [1:0]     rvalid_r;
   logic [31:0]    bram_rd_s;
   logic           rd_live_r;
   logic           last_rd_r;
   logic [31:0]    saved_r [2];
   logic           unused_s;

   assign fresh_req_s[0] = '{addr: p0.addr, be: p0.be, data: p0.data_in, valid: p0.en};
   assign fresh_req_s[1] = '{addr: p1.addr, be: p1.be, data: p1.data_in, valid: p1.en};

   // A fresh request counts only while its port has nothing held.
   assign fresh_v_s[0] = fresh_req_s[0].valid & ~hold_r[0].valid;
   assign fresh_v_s[1] = fresh_req_s[1].valid & ~hold_r[1].valid;

   // Arbitration: held request first, then round-robin between two fresh ones.
   always_comb begin
      grant_v_s    = 1'b0;
      grant_port_s = 1'b0;
      latch_s      = 2'b00;
      collision_s  = 1'b0;
      if (hold_r[0].valid) begin
         grant_v_s    = 1'b1;
         grant_port_s = 1'b0;
         latch_s[1]   = fresh_v_s[1];
      end else if (hold_r[1].valid) begin
         grant_v_s    = 1'b1;
         grant_port_s = 1'b1;
         latch_s[0]   = fresh_v_s[0];
      end else if (fresh_v_s[0] && fresh_v_s[1]) begin
         grant_v_s    = 1'b1;
         grant_port_s = rr_ptr_r;
         collision_s  = 1'b1;
         if (rr_ptr_r) begin
            latch_s = 2'b01;
         end else begin
            latch_s = 2'b10;
         end
      end else if (fresh_v_s[0]) begin
         grant_v_s    = 1'b1;
         grant_port_s = 1'b0;
      end else if (fresh_v_s[1]) begin
         grant_v_s    = 1'b1;
         grant_port_s = 1'b1;
      end else begin
         grant_v_s    = 1'b0;
      end
   end

   // Granted request payload: the held copy if one exists, else the live bus.
   always_comb begin
      grant_req_s = '0;
      if (hold_r[grant_port_s].valid) begin
         grant_req_s = hold_r[grant_port_s];
      end else begin
         grant_req_s = fresh_req_s[grant_port_s];
      end
   end

   assign grant_rd_s = grant_v_s & (grant_req_s.be == 4'b0000);

   // Upper address bits are ignored; valid is implied by grant_v_s.
   assign unused_s = ^{grant_req_s.addr[REQ_ADDR_W-1:ADDR_W], grant_req_s.valid};

   // Reset blocks the array access so nothing is written while rst is high.
   byte_en_bram #(.LINES(LINES)) u_bram (
      .clk   (clk),
      .en    (grant_v_s & ~rst),
      .we    (grant_req_s.be),
      .addr  (grant_req_s.addr[ADDR_W-1:0]),
      .wdata (grant_req_s.data),
      .rdata (bram_rd_s)
   );

   // Hold registers, round-robin pointer, read pulses and output bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_r[0] <= '0;
         hold_r[1] <= '0;
         rr_ptr_r  <= 1'b0;
         rvalid_r  <= 2'b00;
         rd_live_r <= 1'b0;
         last_rd_r <= 1'b0;
         saved_r[0] <= 32'h0000_0000;
         saved_r[1] <= 32'h0000_0000;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (latch_s[i]) begin
               hold_r[i] <= fresh_req_s[i];
            end else if (grant_v_s && (grant_port_s == 1'(i))) begin
               hold_r[i].valid <= 1'b0;
            end
         end
         if (collision_s) begin
            rr_ptr_r <= ~rr_ptr_r;
         end
         rvalid_r[0] <= grant_rd_s & ~grant_port_s;
         rvalid_r[1] <= grant_rd_s &  grant_port_s;
         // The BRAM read register is shared: before it is overwritten, copy
         // out the word it currently shows so that port keeps its data_out.
         if (grant_rd_s) begin
            if (rd_live_r) begin
               saved_r[last_rd_r] <= bram_rd_s;
            end
            rd_live_r <= 1'b1;
            last_rd_r <= grant_port_s;
         end
      end
   end

   assign p0.data_out = (rd_live_r && !last_rd_r) ? bram_rd_s : saved_r[0];
   assign p1.data_out = (rd_live_r &&  last_rd_r) ? bram_rd_s : saved_r[1];
   assign p0.rvalid   = rvalid_r[0];
   assign p1.rvalid   = rvalid_r[1];
   assign p0.busy     = hold_r[0].valid;
   assign p1.busy     = hold_r[1].valid;

`ifdef SHARED_DBRAM_COLLISION_COUNT_EN
   logic [31:0] coll_cnt_r;

   // Saturating count of fresh-vs-fresh collisions.
   always_ff @(posedge clk) begin
      if (rst) begin
         coll_cnt_r <= 32'h0000_0000;
      end else if (collision_s && (coll_cnt_r != 32'hFFFF_FFFF)) begin
         coll_cnt_r <= coll_cnt_r + 32'h0000_0001;
      end
   end

   assign collision_count = coll_cnt_r;
`endif

endmodule
